echo_ctrl: RTL and testbench

ECHO_CTRL -- requirements
Module: echo_ctrl

---
 rtl/echo_ctrl_if.sv | 22 ++
 rtl/echo_ctrl.sv | 169 ++++++++++++++++
 tb/tb_echo_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_ctrl_if.sv
// Receive/transmit FIFO handshake bundle for echo_ctrl.
// master = controller side, slave = FIFO side.
interface echo_ctrl_if #(
   parameter int unsigned WORD_SIZE = 32
);
   logic [WORD_SIZE-1:0] rx_data;
   logic                 rx_empty;
   logic                 rx_rd;
   logic [WORD_SIZE-1:0] tx_data;
   logic                 tx_full;
   logic                 tx_wr;

   modport master (
      input  rx_data, rx_empty, tx_full,
      output rx_rd, tx_data, tx_wr
   );

   modport slave (
      output rx_data, rx_empty, tx_full,
      input  rx_rd, tx_data, tx_wr
   );
endinterface

// File: rtl/echo_ctrl.sv
// Echo controller: reads a block of up to BLOCK_LEN words from the receive
// FIFO, optionally byte-swaps each word and/or reverses word order, then
// writes the block to the transmit FIFO. A partial block is flushed after
// TIMEOUT_CYC idle cycles (0 disables the flush).
module echo_ctrl #(
   parameter int unsigned WORD_SIZE   = 32,
   parameter int unsigned WORD_PART   = 8,
   parameter int unsigned BLOCK_LEN   = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  mode,
   echo_ctrl_if.master bus,
   output logic        busy,
   output logic [15:0] blk_cnt,
   output logic        timeout_pulse
);

   localparam int unsigned LANES = WORD_SIZE / WORD_PART;
   localparam int unsigned CW    = $clog2(BLOCK_LEN + 1);
   localparam int unsigned IW    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam int unsigned TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(BLOCK_LEN);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE,
      FILL_REQ,
      FILL_CAPT,
      DRAIN
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [WORD_SIZE-1:0] buffer [BLOCK_LEN];
   logic [CW-1:0]        count;
   logic [CW-1:0]        k;
   logic [TW-1:0]        to_cnt;
   logic [1:0]           mode_q;
   logic                 start;
   logic                 to_fire;
   logic                 last_wr;
   logic [WORD_SIZE-1:0] swapped;
   logic [CW-1:0]        rd_pos;
   logic [IW-1:0]        rd_idx;

   // Byte-lane swap of the incoming word when the latched mode asks for it.
   always_comb begin
      swapped = bus.rx_data;
      if (mode_q[0]) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            swapped[(LANES-1-i)*WORD_PART +: WORD_PART] = bus.rx_data[i*WORD_PART +: WORD_PART];
         end
      end
   end

   // Drain read pointer: forward or reversed over the words actually captured.
   always_comb begin
      rd_pos      = mode_q[1] ? (count - k - CW'(1)) : k;
      rd_idx      = IW'(rd_pos);
      bus.tx_data = buffer[rd_idx];
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and FIFO strobes; strobes are confined to one state each.
   always_comb begin
      state_next = state;
      bus.rx_rd  = 1'b0;
      bus.tx_wr  = 1'b0;
      start      = 1'b0;
      to_fire    = 1'b0;
      last_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !bus.rx_empty) begin
               start      = 1'b1;
               state_next = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (!bus.rx_empty) begin
               bus.rx_rd  = 1'b1;
               state_next = FILL_CAPT;
            end else if ((TIMEOUT_CYC != 0) && (count != '0) && (to_cnt + TW'(1) == TO_LIMIT)) begin
               to_fire    = 1'b1;
               state_next = DRAIN;
            end
         end
         FILL_CAPT: begin
            state_next = (count + CW'(1) == FULL_CNT) ? DRAIN : FILL_REQ;
         end
         DRAIN: begin
            if (!bus.tx_full) begin
               bus.tx_wr = 1'b1;
               if (k + CW'(1) == count) begin
                  last_wr    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Block bookkeeping: latched mode, word count, drain index, timeout, block counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q        <= '0;
         count         <= '0;
         k             <= '0;
         to_cnt        <= '0;
         blk_cnt       <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= to_fire;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  count  <= '0;
                  k      <= '0;
                  to_cnt <= '0;
               end
            end
            FILL_REQ: begin
               if (bus.rx_empty && (TIMEOUT_CYC != 0) && (count != '0)) begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            FILL_CAPT: begin
               count  <= count + CW'(1);
               to_cnt <= '0;
            end
            DRAIN: begin
               if (bus.tx_wr) begin
                  k <= k + CW'(1);
               end
               if (last_wr) begin
                  blk_cnt <= blk_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Word storage; contents are don't-care after reset since count is cleared.
   always_ff @(posedge clock) begin
      if (state == FILL_CAPT) begin
         buffer[IW'(count)] <= swapped;
      end
   end

   // Busy whenever a block is in progress.
   always_comb begin
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_echo_ctrl.sv
// Directed bench for echo_ctrl (32-bit words, 8-bit lanes, 4-word blocks,
// 8-cycle timeout). A FIFO model on the falling edge feeds rx words and
// logs tx writes; each test task checks its own results.
module tb_echo_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  mode;
   logic        busy;
   logic [15:0] blk_cnt;
   logic        timeout_pulse;

   int total = 0;
   int bad   = 0;

   echo_ctrl_if #(.WORD_SIZE(32)) bus ();

   echo_ctrl #(
      .WORD_SIZE(32),
      .WORD_PART(8),
      .BLOCK_LEN(4),
      .TIMEOUT_CYC(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .mode(mode),
      .bus(bus.master),
      .busy(busy),
      .blk_cnt(blk_cnt),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clock = ~clock;

   // FIFO model state
   logic [31:0] rx_q[$];
   logic [31:0] tx_log[$];
   logic [31:0] rx_next;
   bit          rx_pend = 0;
   int          stall_on_n = 0;
   int          stall_len = 0;
   int          stall_rem = 0;
   int          cyc = 0;
   int          rd_cyc = 0;
   int          pulse_cyc = 0;
   int          pulse_n = 0;
   int          overlap = 0;
   int          full_wr = 0;
   int          stall_seen = 0;

   // Drive FIFO flags mid-cycle, then sample strobes well before the next rising edge.
   always @(negedge clock) begin
      if (rx_pend) begin
         bus.rx_data = rx_next;
         rx_pend = 0;
      end
      bus.rx_empty = (rx_q.size() == 0);
      if (stall_len == 0) stall_rem = 0;
      if (stall_rem > 0) begin
         bus.tx_full = 1'b1;
         stall_rem--;
      end else begin
         bus.tx_full = 1'b0;
      end
      #1;
      cyc++;
      if (bus.rx_rd && bus.tx_wr) overlap++;
      if (bus.tx_full && bus.tx_wr) full_wr++;
      if (bus.tx_full && busy) stall_seen++;
      if (timeout_pulse) begin
         pulse_n++;
         pulse_cyc = cyc;
      end
      if (bus.rx_rd && rx_q.size() > 0) begin
         rx_next = rx_q.pop_front();
         rx_pend = 1;
         rd_cyc = cyc;
      end
      if (bus.tx_wr) begin
         tx_log.push_back(bus.tx_data);
         if (stall_len != 0 && stall_on_n != 0 && tx_log.size() == stall_on_n) stall_rem = stall_len;
      end
   end

   // Load n words, start a block, alter enable/mode once it is running, wait for completion.
   task automatic run_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3,
                            input int n, input logic [1:0] m, output bit done);
      logic [31:0] w[4];
      logic [15:0] old;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      done = 0;
      tx_log.delete();
      for (int i = 0; i < n; i++) rx_q.push_back(w[i]);
      mode = m;
      @(negedge clock);
      @(negedge clock);
      enable = 1'b1;
      old = blk_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         #2;
         if (busy) break;
      end
      mode = ~m;
      enable = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         #2;
         if (blk_cnt != old) begin
            done = 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (bus.rx_rd !== 1'b0) begin bad++; $display("FAIL rst_rx_rd got=%b want=0", bus.rx_rd); end
      total++; if (bus.tx_wr !== 1'b0) begin bad++; $display("FAIL rst_tx_wr got=%b want=0", bus.tx_wr); end
      total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got=%b want=0", timeout_pulse); end
      total++; if (blk_cnt !== 16'h0000) begin bad++; $display("FAIL rst_blk_cnt got=%h want=0000", blk_cnt); end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
      total++; if (bus.rx_rd !== 1'b0) begin bad++; $display("FAIL post_rst_rx_rd got=%b want=0", bus.rx_rd); end
      total++; if (bus.tx_wr !== 1'b0) begin bad++; $display("FAIL post_rst_tx_wr got=%b want=0", bus.tx_wr); end
   endtask

   task automatic test_plain;
      bit done;
      logic [31:0] exp[4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
      int ov0 = overlap;
      run_block(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 4, 2'b00, done);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL plain_done got=%b want=1", done); end
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL plain_nwr got=%0d want=4", tx_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (tx_log[i] !== exp[i]) begin bad++; $display("FAIL plain_w%0d got=%h want=%h", i, tx_log[i], exp[i]); end
      end
      total++; if (blk_cnt !== 16'd1) begin bad++; $display("FAIL plain_blk got=%0d want=1", blk_cnt); end
      total++; if (overlap != ov0) begin bad++; $display("FAIL plain_overlap got=%0d want=%0d", overlap, ov0); end
   endtask

   task automatic test_swap;
      bit done;
      run_block(32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344, 4, 2'b01, done);
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL swap_nwr got=%0d want=4", tx_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (tx_log[i] !== 32'h44332211) begin bad++; $display("FAIL swap_w%0d got=%h want=44332211", i, tx_log[i]); end
      end
      total++; if (blk_cnt !== 16'd2) begin bad++; $display("FAIL swap_blk got=%0d want=2", blk_cnt); end
   endtask

   task automatic test_reverse;
      bit done;
      logic [31:0] exp_r[4]  = '{32'd4, 32'd3, 32'd2, 32'd1};
      logic [31:0] exp_rs[4] = '{32'hDDCCBBAA, 32'h0, 32'h0, 32'h44332211};
      run_block(32'd1, 32'd2, 32'd3, 32'd4, 4, 2'b10, done);
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL rev_nwr got=%0d want=4", tx_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (tx_log[i] !== exp_r[i]) begin bad++; $display("FAIL rev_w%0d got=%h want=%h", i, tx_log[i], exp_r[i]); end
      end
      run_block(32'h11223344, 32'h0, 32'h0, 32'hAABBCCDD, 4, 2'b11, done);
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL revswap_nwr got=%0d want=4", tx_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (tx_log[i] !== exp_rs[i]) begin bad++; $display("FAIL revswap_w%0d got=%h want=%h", i, tx_log[i], exp_rs[i]); end
      end
      total++; if (blk_cnt !== 16'd4) begin bad++; $display("FAIL rev_blk got=%0d want=4", blk_cnt); end
   endtask

   task automatic test_stall;
      bit done;
      int fw0 = full_wr;
      int ss0 = stall_seen;
      stall_on_n = 2;
      stall_len = 5;
      run_block(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 4, 2'b00, done);
      stall_len = 0;
      stall_on_n = 0;
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL stall_nwr got=%0d want=4", tx_log.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (tx_log[i] !== 32'hA0000001 + i) begin bad++; $display("FAIL stall_w%0d got=%h want=%h", i, tx_log[i], 32'hA0000001 + i); end
      end
      total++; if (stall_seen - ss0 != 5) begin bad++; $display("FAIL stall_cycles got=%0d want=5", stall_seen - ss0); end
      total++; if (full_wr != fw0) begin bad++; $display("FAIL stall_wr_while_full got=%0d want=%0d", full_wr, fw0); end
      total++; if (blk_cnt !== 16'd5) begin bad++; $display("FAIL stall_blk got=%0d want=5", blk_cnt); end
   endtask

   task automatic test_timeout;
      bit done;
      int p0 = pulse_n;
      int gap;
      run_block(32'hA, 32'hB, 32'h0, 32'h0, 2, 2'b10, done);
      gap = pulse_cyc - rd_cyc;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL to_done got=%b want=1", done); end
      total++; if (pulse_n - p0 != 1) begin bad++; $display("FAIL to_pulses got=%0d want=1", pulse_n - p0); end
      total++; if (gap < 9 || gap > 10) begin bad++; $display("FAIL to_delay got=%0d want=9..10", gap); end
      total++; if (tx_log.size() != 2) begin bad++; $display("FAIL to_nwr got=%0d want=2", tx_log.size()); end
      else begin
         total++; if (tx_log[0] !== 32'hB) begin bad++; $display("FAIL to_w0 got=%h want=0000000b", tx_log[0]); end
         total++; if (tx_log[1] !== 32'hA) begin bad++; $display("FAIL to_w1 got=%h want=0000000a", tx_log[1]); end
      end
      total++; if (blk_cnt !== 16'd6) begin bad++; $display("FAIL to_blk got=%0d want=6", blk_cnt); end
   endtask

   task automatic test_reset_mid;
      bit done;
      tx_log.delete();
      stall_on_n = 1;
      stall_len = 1000;
      for (int i = 0; i < 4; i++) rx_q.push_back(32'hCAFE0000 + i);
      mode = 2'b00;
      @(negedge clock);
      @(negedge clock);
      enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         #2;
         if (tx_log.size() >= 1) break;
      end
      enable = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #2;
      total++; if (tx_log.size() != 1) begin bad++; $display("FAIL mid_wr_before got=%0d want=1", tx_log.size()); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
      total++; if (bus.tx_wr !== 1'b0 || bus.rx_rd !== 1'b0) begin bad++; $display("FAIL mid_strobes got=%b%b want=00", bus.tx_wr, bus.rx_rd); end
      total++; if (timeout_pulse !== 1'b0) begin bad++; $display("FAIL mid_pulse got=%b want=0", timeout_pulse); end
      total++; if (blk_cnt !== 16'd0) begin bad++; $display("FAIL mid_blk got=%0d want=0", blk_cnt); end
      stall_len = 0;
      stall_on_n = 0;
      reset = 1'b0;
      @(negedge clock);
      run_block(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 4, 2'b00, done);
      total++; if (tx_log.size() != 4) begin bad++; $display("FAIL after_nwr got=%0d want=4", tx_log.size()); end
      else begin
         total++; if (tx_log[0] !== 32'h01020304) begin bad++; $display("FAIL after_w0 got=%h want=01020304", tx_log[0]); end
         total++; if (tx_log[1] !== 32'h05060708) begin bad++; $display("FAIL after_w1 got=%h want=05060708", tx_log[1]); end
         total++; if (tx_log[2] !== 32'h090A0B0C) begin bad++; $display("FAIL after_w2 got=%h want=090a0b0c", tx_log[2]); end
         total++; if (tx_log[3] !== 32'h0D0E0F10) begin bad++; $display("FAIL after_w3 got=%h want=0d0e0f10", tx_log[3]); end
      end
      total++; if (blk_cnt !== 16'd1) begin bad++; $display("FAIL after_blk got=%0d want=1", blk_cnt); end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      mode   = 2'b00;
      repeat (3) @(negedge clock);
      test_reset;
      test_plain;
      test_swap;
      test_reverse;
      test_stall;
      test_timeout;
      test_reset_mid;
      total++; if (overlap != 0) begin bad++; $display("FAIL rd_wr_overlap got=%0d want=0", overlap); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
